// File: rtl/pl_if_ctrl_pkg.sv
// Shared encodings for the IF/ID sequencer: next-PC select values (also used by
// the datapath PC mux) and the controller state encoding.
package pl_if_ctrl_pkg;

  typedef enum logic [1:0] {
    PCS_SEQ = 2'b00,
    PCS_BR  = 2'b01,
    PCS_VEC = 2'b10,
    PCS_EPC = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_VECTOR = 2'b10
  } state_e;

endpackage

// File: rtl/pl_if_ctrl_if.sv
// Hazard/redirect inputs from the pipeline and the PC / IF-ID control outputs.
// master = datapath side, slave = sequencer.
interface pl_if_ctrl_if;
  import pl_if_ctrl_pkg::*;

  logic        ld_stall;
  logic        fpu_stall;
  logic        br_taken;
  logic        mret;
  logic        irq;
  logic        irq_en;
  logic [31:0] pc;
  logic [31:0] dpc;

  logic        wpcir;
  logic        flush_ir;
  pc_sel_e     pc_sel;
  logic [31:0] epc;
  logic        epc_we;
  logic        int_ack;
  logic        in_handler;

  modport master (
    output ld_stall, fpu_stall, br_taken, mret, irq, irq_en, pc, dpc,
    input  wpcir, flush_ir, pc_sel, epc, epc_we, int_ack, in_handler
  );

  modport slave (
    input  ld_stall, fpu_stall, br_taken, mret, irq, irq_en, pc, dpc,
    output wpcir, flush_ir, pc_sel, epc, epc_we, int_ack, in_handler
  );

endinterface

// File: rtl/pl_if_ctrl.sv
// IF/ID pipeline register and PC write sequencer: stalls, branch redirect, MRET,
// and precise interrupt entry (capture EPC, drain older work, vector).
module pl_if_ctrl
  import pl_if_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CW           = 4
) (
  input logic         clk,
  input logic         clr,
  pl_if_ctrl_if.slave bus
);

  state_e        state;
  logic [CW-1:0] cnt;
  logic          id_valid;
  logic          in_handler;
  logic [31:0]   epc;

  logic          stall;
  logic          mret_ok;
  logic          take_irq;
  logic          br_ok;

  logic          wpcir;
  logic          flush_ir;
  pc_sel_e       pc_sel;
  logic          epc_we;
  logic          int_ack;

  assign stall    = bus.ld_stall | bus.fpu_stall;
  assign mret_ok  = bus.mret & id_valid;
  assign take_irq = bus.irq & bus.irq_en & ~in_handler;
  assign br_ok    = bus.br_taken & id_valid;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    wpcir    = 1'b1;
    flush_ir = 1'b0;
    pc_sel   = PCS_SEQ;
    epc_we   = 1'b0;
    int_ack  = 1'b0;
    if (clr) begin
      wpcir    = 1'b0;
      flush_ir = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (stall) begin
            wpcir = 1'b0;
          end else if (mret_ok) begin
            flush_ir = 1'b1;
            pc_sel   = PCS_EPC;
          end else if (take_irq) begin
            // Freeze IF/ID for the capture cycle; the ID instruction re-executes on return.
            wpcir  = 1'b0;
            epc_we = 1'b1;
          end else if (br_ok) begin
            flush_ir = 1'b1;
            pc_sel   = PCS_BR;
          end
        end
        ST_DRAIN: begin
          flush_ir = 1'b1;
          wpcir    = ~bus.fpu_stall;
        end
        ST_VECTOR: begin
          flush_ir = 1'b1;
          pc_sel   = PCS_VEC;
          int_ack  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (clr) begin
      state      <= ST_RUN;
      cnt        <= '0;
      id_valid   <= 1'b0;
      in_handler <= 1'b0;
      epc        <= '0;
    end else begin
      if (wpcir)  id_valid <= ~flush_ir;
      if (epc_we) epc      <= id_valid ? bus.dpc : bus.pc;
      case (state)
        ST_RUN: begin
          if (pc_sel == PCS_EPC) in_handler <= 1'b0;
          if (epc_we) begin
            state <= ST_DRAIN;
            cnt   <= CW'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (!bus.fpu_stall) begin
            if (cnt == '0) state <= ST_VECTOR;
            else           cnt   <= cnt - 1'b1;
          end
        end
        ST_VECTOR: begin
          in_handler <= 1'b1;
          state      <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.wpcir      = wpcir;
  assign bus.flush_ir   = flush_ir;
  assign bus.pc_sel     = pc_sel;
  assign bus.epc        = epc;
  assign bus.epc_we     = epc_we;
  assign bus.int_ack    = int_ack;
  assign bus.in_handler = in_handler;

endmodule
